ysyx_22050710_mem_stage: RTL and testbench

Memory-access pipeline stage between execute and write-back. It latches the execute-stage bus under valid/allowin handshaking and issues loads and stores to the data bus using a two-phase request/response protocol. It aligns and sign/zero-extends load data, then forwards the final GPR/CSR write information to write-back in the same bus layout write-back already unpacks. It also drives a bypass bus to decode and carries the debug bus one stage forward.

---
 rtl/ysyx_22050710_mem_stage.sv | 196 +++++++++++++++++++
 tb/tb_ysyx_22050710_mem_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_mem_stage.sv
// ysyx_22050710_mem_stage
//
// Memory-access pipeline stage between execute and write-back. It latches the execute bus
// under valid/allowin handshaking and issues loads and stores on a two-phase (addr_ok /
// data_ok) data bus. It aligns and extends load data and forwards the final GPR/CSR write
// information to write-back. It also drives a bypass bus to decode and carries the debug
// bus one stage forward.
//
// Ports:
//   i_clk, i_rst               clock; synchronous active-high reset
//   o_ms_allowin               stage can take a new entry this cycle
//   i_es_to_ms_valid/_bus      entry from execute
//   i_ws_allowin               write-back can accept
//   o_ms_to_ws_valid/_bus      {gpr_wen, rd, gpr_final_result, csr_wen, csr, csr_final_result}
//   o_ms_to_ds_bypass_bus      {fwd_ready, rd, gpr_data, csr, csr_data}
//   o_data_req/_wr/_addr/_wdata/_wmask, i_data_addr_ok     request phase
//   i_data_data_ok, i_data_rdata                           response phase
//   i_debug_es_to_ms_bus / o_debug_ms_to_ws_bus            debug fields, passed through
//
// Configuration macro: YSYX_22050710_MS_BYPASS_EN
//   defined   -> bypass bus is driven from the stage contents
//   undefined -> bypass bus is tied to zero (decode relies on interlock)

module ysyx_22050710_mem_stage #(
  parameter int unsigned WORD_WD         = 64,
  parameter int unsigned GPR_ADDR_WD     = 5,
  parameter int unsigned CSR_ADDR_WD     = 12,
  parameter int unsigned ES_TO_MS_BUS_WD = 288,
  parameter int unsigned MS_TO_WS_BUS_WD = 147,
  parameter int unsigned BYPASS_BUS_WD   = 146,
  parameter int unsigned DEBUG_BUS_WD    = 1 + 1 + 32 + 64 + 64 + 1 + 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_ms_allowin,
  input  logic                       i_es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] i_es_to_ms_bus,
  input  logic                       i_ws_allowin,
  output logic                       o_ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] o_ms_to_ws_bus,
  output logic [BYPASS_BUS_WD-1:0]   o_ms_to_ds_bypass_bus,
  output logic                       o_data_req,
  output logic                       o_data_wr,
  output logic [WORD_WD-1:0]         o_data_addr,
  output logic [WORD_WD-1:0]         o_data_wdata,
  output logic [7:0]                 o_data_wmask,
  input  logic                       i_data_addr_ok,
  input  logic                       i_data_data_ok,
  input  logic [WORD_WD-1:0]         i_data_rdata,
  input  logic [DEBUG_BUS_WD-1:0]    i_debug_es_to_ms_bus,
  output logic [DEBUG_BUS_WD-1:0]    o_debug_ms_to_ws_bus
);

  // Execute-bus fields, MSB first. The used fields fill the low bits of the bus.
  typedef struct packed {
    logic                   mem_en;
    logic                   mem_wr;
    logic [2:0]             mem_op;
    logic [WORD_WD-1:0]     mem_addr;
    logic [WORD_WD-1:0]     mem_wdata;
    logic                   gpr_wen;
    logic [GPR_ADDR_WD-1:0] rd;
    logic [WORD_WD-1:0]     alu_result;
    logic                   csr_wen;
    logic [CSR_ADDR_WD-1:0] csr;
    logic [WORD_WD-1:0]     csr_result;
  } es_bus_t;

  localparam int unsigned EsUsedWd = $bits(es_bus_t);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e                  state_q;
  logic                    ms_valid_q;
  es_bus_t                 es_q;
  logic [DEBUG_BUS_WD-1:0] debug_q;
  logic [WORD_WD-1:0]      rdata_q;

  logic ms_ready_go;
  logic handoff;

  // Padding bits above the used fields carry no information.
  logic unused_es_pad;
  assign unused_es_pad = ^i_es_to_ms_bus[ES_TO_MS_BUS_WD-1:EsUsedWd];

  assign ms_ready_go      = !es_q.mem_en || (state_q == StDone);
  assign o_ms_allowin     = !ms_valid_q || (ms_ready_go && i_ws_allowin);
  assign o_ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign handoff          = o_ms_to_ws_valid && i_ws_allowin;
  assign o_data_req       = ms_valid_q && es_q.mem_en && (state_q == StIdle);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      ms_valid_q <= 1'b0;
      es_q       <= '0;
      debug_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (o_ms_allowin) begin
        ms_valid_q <= i_es_to_ms_valid;
      end
      if (i_es_to_ms_valid && o_ms_allowin) begin
        es_q    <= es_bus_t'(i_es_to_ms_bus[EsUsedWd-1:0]);
        debug_q <= i_debug_es_to_ms_bus;
      end
      // Responses are only taken in StWait, so stale or stray data_ok pulses are dropped.
      unique case (state_q)
        StIdle: begin
          if (o_data_req && i_data_addr_ok) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (i_data_data_ok) begin
            state_q <= StDone;
            rdata_q <= i_data_rdata;
          end
        end
        StDone: begin
          if (handoff) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Request phase. Outputs derive only from registered state, so they hold until addr_ok.
  logic [2:0]         byte_off;
  logic [5:0]         bit_off;
  logic [7:0]         size_mask;
  logic [WORD_WD-1:0] shifted;
  logic [WORD_WD-1:0] load_data;
  logic [WORD_WD-1:0] gpr_final_result;

  assign byte_off = es_q.mem_addr[2:0];
  assign bit_off  = {byte_off, 3'b000};

  always_comb begin
    size_mask = 8'h01;
    unique case (es_q.mem_op[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0f;
      2'b11:   size_mask = 8'hff;
      default: size_mask = 8'h01;
    endcase
  end

  assign o_data_wr    = o_data_req && es_q.mem_wr;
  assign o_data_addr  = o_data_req ? {es_q.mem_addr[WORD_WD-1:3], 3'b000} : '0;
  assign o_data_wdata = o_data_req ? (es_q.mem_wdata << bit_off) : '0;
  assign o_data_wmask = o_data_req ? (size_mask << byte_off) : 8'h00;

  // Load alignment and extension.
  assign shifted = rdata_q >> bit_off;

  always_comb begin
    load_data = shifted;
    case (es_q.mem_op)
      3'b000:  load_data = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_data = shifted;
      3'b100:  load_data = {56'd0, shifted[7:0]};
      3'b101:  load_data = {48'd0, shifted[15:0]};
      3'b110:  load_data = {32'd0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  assign gpr_final_result = (es_q.mem_en && !es_q.mem_wr) ? load_data : es_q.alu_result;

  assign o_ms_to_ws_bus = {es_q.gpr_wen, es_q.rd, gpr_final_result,
                           es_q.csr_wen, es_q.csr, es_q.csr_result};

  assign o_debug_ms_to_ws_bus = debug_q;

`ifdef YSYX_22050710_MS_BYPASS_EN
  always_comb begin
    o_ms_to_ds_bypass_bus = '0;
    if (ms_valid_q) begin
      o_ms_to_ds_bypass_bus = {ms_ready_go,
                               es_q.gpr_wen ? es_q.rd : {GPR_ADDR_WD{1'b0}},
                               es_q.gpr_wen ? gpr_final_result : {WORD_WD{1'b0}},
                               es_q.csr_wen ? es_q.csr : {CSR_ADDR_WD{1'b0}},
                               es_q.csr_wen ? es_q.csr_result : {WORD_WD{1'b0}}};
    end
  end
`else
  assign o_ms_to_ds_bypass_bus = '0;
`endif

endmodule

// File: tb/tb_ysyx_22050710_mem_stage.sv
module tb_ysyx_22050710_mem_stage;

  localparam int DbgWd = 227;

  logic          clk;
  logic          rst;
  logic          ms_allowin;
  logic          es_valid;
  logic [287:0]  es_bus;
  logic          ws_allowin;
  logic          ws_valid;
  logic [146:0]  ws_bus;
  logic [145:0]  bypass;
  logic          data_req;
  logic          data_wr;
  logic [63:0]   data_addr;
  logic [63:0]   data_wdata;
  logic [7:0]    data_wmask;
  logic          addr_ok;
  logic          data_ok;
  logic [63:0]   rdata;
  logic [DbgWd-1:0] dbg_in;
  logic [DbgWd-1:0] dbg_out;

  int checks = 0;
  int failures = 0;

  ysyx_22050710_mem_stage dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .o_ms_allowin          (ms_allowin),
    .i_es_to_ms_valid      (es_valid),
    .i_es_to_ms_bus        (es_bus),
    .i_ws_allowin          (ws_allowin),
    .o_ms_to_ws_valid      (ws_valid),
    .o_ms_to_ws_bus        (ws_bus),
    .o_ms_to_ds_bypass_bus (bypass),
    .o_data_req            (data_req),
    .o_data_wr             (data_wr),
    .o_data_addr           (data_addr),
    .o_data_wdata          (data_wdata),
    .o_data_wmask          (data_wmask),
    .i_data_addr_ok        (addr_ok),
    .i_data_data_ok        (data_ok),
    .i_data_rdata          (rdata),
    .i_debug_es_to_ms_bus  (dbg_in),
    .o_debug_ms_to_ws_bus  (dbg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_en;
    logic        mem_wr;
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        gpr_wen;
    logic [4:0]  rd;
    logic [63:0] alu;
    logic        csr_wen;
    logic [11:0] csr;
    logic [63:0] csr_res;
  } txn_t;

  task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [DbgWd-1:0] rdbg();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v[DbgWd-1:0];
  endfunction

  function automatic logic [287:0] pack_es(input txn_t t);
    return {8'd0, t.mem_en, t.mem_wr, t.op, t.addr, t.wdata, t.gpr_wen, t.rd, t.alu,
            t.csr_wen, t.csr, t.csr_res};
  endfunction

  // Reference behaviour expressed on bytes: pick the accessed bytes, then extend.
  function automatic logic [63:0] load_val(input txn_t t, input logic [63:0] rd_word);
    int n;
    int off;
    logic [63:0] v;
    n = 1 << t.op[1:0];
    off = int'(t.addr[2:0]);
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (off + i < 8) v[8*i +: 8] = rd_word[8*(off+i) +: 8];
    end
    if (!t.op[2] && n < 8 && v[8*n-1]) begin
      for (int b = 8 * n; b < 64; b++) v[b] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [63:0] store_data(input txn_t t);
    int off;
    logic [63:0] v;
    off = int'(t.addr[2:0]);
    v = '0;
    for (int i = 0; i < 8; i++) begin
      if (off + i < 8) v[8*(off+i) +: 8] = t.wdata[8*i +: 8];
    end
    return v;
  endfunction

  function automatic logic [7:0] store_mask(input txn_t t);
    int off;
    logic [7:0] m;
    off = int'(t.addr[2:0]);
    m = '0;
    for (int i = 0; i < (1 << t.op[1:0]); i++) begin
      if (off + i < 8) m[off+i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [63:0] result_of(input txn_t t, input logic [63:0] rd_word);
    return (t.mem_en && !t.mem_wr) ? load_val(t, rd_word) : t.alu;
  endfunction

  function automatic logic [146:0] exp_ws(input txn_t t, input logic [63:0] rd_word);
    return {t.gpr_wen, t.rd, result_of(t, rd_word), t.csr_wen, t.csr, t.csr_res};
  endfunction

  // Bypass contents while the stage holds a finished instruction.
  function automatic logic [145:0] exp_byp(input txn_t t, input logic [63:0] rd_word);
`ifdef YSYX_22050710_MS_BYPASS_EN
    return {1'b1, t.gpr_wen ? t.rd : 5'd0, t.gpr_wen ? result_of(t, rd_word) : 64'd0,
            t.csr_wen ? t.csr : 12'd0, t.csr_wen ? t.csr_res : 64'd0};
`else
    return (t.rd == 5'd0 && rd_word == 64'd0) ? '0 : '0;
`endif
  endfunction

  function automatic txn_t mk_rand();
    txn_t t;
    int kind;
    int n;
    logic [63:0] a;
    kind = $urandom_range(0, 2);
    t.mem_en = (kind != 0);
    t.mem_wr = (kind == 2);
    t.op = (kind == 2) ? {1'b0, 2'($urandom_range(0, 3))} : 3'($urandom_range(0, 6));
    n = 1 << t.op[1:0];
    a = r64();
    t.addr = {a[63:3], 3'(($urandom_range(0, 7) / n) * n)};
    t.wdata = r64();
    t.gpr_wen = 1'($urandom_range(0, 1));
    t.rd = 5'($urandom);
    t.alu = r64();
    t.csr_wen = 1'($urandom_range(0, 1));
    t.csr = 12'($urandom);
    t.csr_res = r64();
    return t;
  endfunction

  // Drives one instruction through the stage and checks every cycle it occupies.
  // When b2b is set, an ALU instruction nxt enters on the handoff cycle.
  task automatic run_txn(input string nm, input txn_t t, input int addr_dly, input int data_dly,
                         input int stall, input logic [63:0] rd_word, input bit b2b,
                         input txn_t nxt);
    logic [DbgWd-1:0] dbg;
    dbg = rdbg();
    ws_allowin = 1'b1;
    es_valid = 1'b1;
    es_bus = pack_es(t);
    dbg_in = dbg;
    #1;
    check({nm, ":allowin_entry"}, ms_allowin, 1);
    tick();
    es_valid = 1'b0;
    es_bus = {r64(), r64(), r64(), r64(), 32'($urandom)};
    dbg_in = rdbg();
    #1;
    check({nm, ":debug"}, dbg_out, dbg);
    if (!t.mem_en) begin
      check({nm, ":no_req"}, data_req, 0);
    end else begin
      for (int i = 0; i <= addr_dly; i++) begin
        addr_ok = (i == addr_dly);
        #1;
        check({nm, ":req"}, data_req, 1);
        check({nm, ":wr"}, data_wr, t.mem_wr);
        check({nm, ":addr"}, data_addr, {t.addr[63:3], 3'b000});
        check({nm, ":wmask"}, data_wmask, t.mem_wr ? store_mask(t) : (store_mask(t) & 8'hff));
        check({nm, ":wdata"}, data_wdata, store_data(t));
        check({nm, ":allowin_req"}, ms_allowin, 0);
        check({nm, ":valid_req"}, ws_valid, 0);
        tick();
      end
      addr_ok = 1'b0;
      for (int i = 0; i <= data_dly; i++) begin
        data_ok = (i == data_dly);
        rdata = (i == data_dly) ? rd_word : r64();
        #1;
        check({nm, ":req_wait"}, data_req, 0);
        check({nm, ":valid_wait"}, ws_valid, 0);
        check({nm, ":allowin_wait"}, ms_allowin, 0);
        check({nm, ":fwd_ready_wait"}, bypass[145], 0);
        tick();
      end
      data_ok = 1'b0;
    end
    for (int i = 0; i < stall; i++) begin
      ws_allowin = 1'b0;
      data_ok = 1'($urandom_range(0, 1));
      rdata = r64();
      #1;
      check({nm, ":valid_stall"}, ws_valid, 1);
      check({nm, ":bus_stall"}, ws_bus, exp_ws(t, rd_word));
      check({nm, ":allowin_stall"}, ms_allowin, 0);
      check({nm, ":bypass_stall"}, bypass, exp_byp(t, rd_word));
      tick();
    end
    data_ok = 1'b0;
    ws_allowin = 1'b1;
    if (b2b) begin
      es_valid = 1'b1;
      es_bus = pack_es(nxt);
    end
    #1;
    check({nm, ":valid"}, ws_valid, 1);
    check({nm, ":bus"}, ws_bus, exp_ws(t, rd_word));
    check({nm, ":bypass"}, bypass, exp_byp(t, rd_word));
    check({nm, ":allowin_handoff"}, ms_allowin, 1);
    tick();
    es_valid = 1'b0;
    if (b2b) begin
      #1;
      check({nm, ":b2b_valid"}, ws_valid, 1);
      check({nm, ":b2b_bus"}, ws_bus, exp_ws(nxt, 64'd0));
      check({nm, ":b2b_no_req"}, data_req, 0);
      tick();
    end
    #1;
    check({nm, ":empty_valid"}, ws_valid, 0);
    check({nm, ":empty_bypass"}, bypass, 0);
  endtask

  initial begin
    txn_t t;
    txn_t alu_nxt;
    rst = 1'b1;
    es_valid = 1'b0;
    es_bus = '0;
    ws_allowin = 1'b1;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rdata = '0;
    dbg_in = '0;
    alu_nxt = '0;
    tick();
    tick();
    rst = 1'b0;
    // Stale response right after reset must be ignored.
    data_ok = 1'b1;
    rdata = 64'hdead_beef_0000_0001;
    #1;
    check("rst:allowin", ms_allowin, 1);
    check("rst:valid", ws_valid, 0);
    check("rst:ws_bus", ws_bus, 0);
    check("rst:bypass", bypass, 0);
    check("rst:req", data_req, 0);
    check("rst:wr", data_wr, 0);
    check("rst:addr", data_addr, 0);
    check("rst:wdata", data_wdata, 0);
    check("rst:wmask", data_wmask, 0);
    check("rst:debug", dbg_out, 0);
    tick();
    data_ok = 1'b0;
    #1;
    check("stale:valid", ws_valid, 0);

    // ALU op
    t = '0;
    t.gpr_wen = 1'b1;
    t.rd = 5'd5;
    t.alu = 64'h1234;
    run_txn("alu", t, 0, 0, 0, 64'd0, 1'b0, alu_nxt);

    // LB with sign extension
    t = '0;
    t.mem_en = 1'b1;
    t.op = 3'b000;
    t.addr = 64'h8000_0003;
    t.gpr_wen = 1'b1;
    t.rd = 5'd7;
    run_txn("lb", t, 0, 2, 0, 64'h0000_0000_8000_0000, 1'b0, alu_nxt);
    check("lb:const", load_val(t, 64'h0000_0000_8000_0000) == 64'hffff_ffff_ffff_ff80, 1);

    // SH at the top halfword
    t = '0;
    t.mem_en = 1'b1;
    t.mem_wr = 1'b1;
    t.op = 3'b001;
    t.addr = 64'h8000_0006;
    t.wdata = 64'habcd;
    run_txn("sh", t, 0, 0, 0, 64'd0, 1'b0, alu_nxt);

    // addr_ok held off for 4 cycles
    t = '0;
    t.mem_en = 1'b1;
    t.op = 3'b011;
    t.addr = 64'h8000_1000;
    t.gpr_wen = 1'b1;
    t.rd = 5'd9;
    run_txn("ld_slow", t, 4, 1, 0, r64(), 1'b0, alu_nxt);

    // LWU with write-back stall, then back-to-back ALU entry
    t = '0;
    t.mem_en = 1'b1;
    t.op = 3'b110;
    t.addr = 64'h8000_0024;
    t.gpr_wen = 1'b1;
    t.rd = 5'd11;
    t.csr_wen = 1'b1;
    t.csr = 12'h300;
    t.csr_res = 64'h55;
    alu_nxt = '0;
    alu_nxt.gpr_wen = 1'b1;
    alu_nxt.rd = 5'd12;
    alu_nxt.alu = 64'h7777;
    run_txn("lwu", t, 0, 0, 3, 64'h8765_4321_0fed_cba9, 1'b1, alu_nxt);

    // Reset while waiting for the response
    t = '0;
    t.mem_en = 1'b1;
    t.op = 3'b010;
    t.addr = 64'h8000_0040;
    t.gpr_wen = 1'b1;
    t.rd = 5'd3;
    es_valid = 1'b1;
    es_bus = pack_es(t);
    tick();
    es_valid = 1'b0;
    addr_ok = 1'b1;
    #1;
    check("rstw:req", data_req, 1);
    tick();
    addr_ok = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rstw:valid", ws_valid, 0);
    check("rstw:req", data_req, 0);
    check("rstw:allowin", ms_allowin, 1);
    check("rstw:bypass", bypass, 0);
    data_ok = 1'b1;
    rdata = r64();
    tick();
    data_ok = 1'b0;
    #1;
    check("rstw:valid_after_resp", ws_valid, 0);
    check("rstw:bypass_after_resp", bypass, 0);
    run_txn("post_rst", t, 0, 1, 0, r64(), 1'b0, alu_nxt);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      t = mk_rand();
      run_txn("rand", t, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
              r64(), 1'($urandom_range(0, 1)), mk_rand() & ~(txn_t'(1) << ($bits(txn_t) - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
